// File: rtl/word_store_sequencer_pkg.sv
// word_store_sequencer_pkg: shared widths and FSM state encoding for the word store sequencer
package word_store_sequencer_pkg;

    localparam int BYTE_WIDTH = 8;
    localparam int WORD_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_FIRST  = 3'd1,
        WR_SECOND = 3'd2,
        FIN       = 3'd3,
        ABORT     = 3'd4
    } state_t;

endpackage

// File: rtl/word_store_sequencer.sv
// word_store_sequencer: stores a 16-bit word into byte-wide memory as one or two handshaked byte writes
module word_store_sequencer
    import word_store_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [WORD_WIDTH-1:0] Data,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic                  ByteOnly,
    input  logic                  BigEndian,
    input  logic                  MemReady,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic [BYTE_WIDTH-1:0] MemData,
    output logic                  MemEn,
    output logic                  MemWr,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error
);

    localparam int CW = MAX_WAIT == 0 ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    state_t state, nxt;
    logic [WORD_WIDTH-1:0] data_l;
    logic [ADDR_WIDTH-1:0] addr_l;
    logic byte_only_l, big_l;
    logic [CW-1:0] wait_cnt;
    logic timeout;

    // the write that would bring the counter to MAX_WAIT ends the transfer instead
    assign timeout = (MAX_WAIT != 0) && !MemReady && (wait_cnt == LAST);

    // next-state decode; outputs are registered from this so nothing combinational reaches a port
    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = Start ? WR_FIRST : IDLE;
            WR_FIRST:  nxt = MemReady ? (byte_only_l ? FIN : WR_SECOND) : (timeout ? ABORT : WR_FIRST);
            WR_SECOND: nxt = MemReady ? FIN : (timeout ? ABORT : WR_SECOND);
            default:   nxt = IDLE;
        endcase
    end

    // state, latched request, wait counter and registered memory-side outputs
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state       <= IDLE;
            data_l      <= '0;
            addr_l      <= '0;
            byte_only_l <= 1'b0;
            big_l       <= 1'b0;
            wait_cnt    <= '0;
            MemAddr     <= '0;
            MemData     <= '0;
            MemEn       <= 1'b0;
            MemWr       <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Error       <= 1'b0;
        end else begin
            state <= nxt;
            Busy  <= (nxt == WR_FIRST) || (nxt == WR_SECOND);
            MemEn <= (nxt == WR_FIRST) || (nxt == WR_SECOND);
            MemWr <= (nxt == WR_FIRST) || (nxt == WR_SECOND);
            Done  <= nxt == FIN;
            Error <= nxt == ABORT;
            if (state == IDLE && Start) begin
                data_l      <= Data;
                addr_l      <= Address;
                byte_only_l <= ByteOnly;
                big_l       <= BigEndian;
                wait_cnt    <= '0;
                MemAddr     <= Address;
                MemData     <= (BigEndian && !ByteOnly) ? Data[15:8] : Data[7:0];
            end else if (state == WR_FIRST || state == WR_SECOND) begin
                if (MemReady)
                    wait_cnt <= '0;
                else if (wait_cnt != CNT_MAX)
                    wait_cnt <= wait_cnt + 1'b1;
                if (state == WR_FIRST && MemReady && !byte_only_l) begin
                    MemAddr <= addr_l + 1'b1;
                    MemData <= big_l ? data_l[7:0] : data_l[15:8];
                end
            end
        end
    end

endmodule

// File: tb/tb_word_store_sequencer.sv
// tb_word_store_sequencer: directed stores checked through an expected-event scoreboard
module tb_word_store_sequencer;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [7:0]  data;
    } ev_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [15:0] Data = '0;
    logic [15:0] Address = '0;
    logic        ByteOnly = 1'b0;
    logic        BigEndian = 1'b0;
    logic        MemReady = 1'b0;
    logic [15:0] MemAddr;
    logic [7:0]  MemData;
    logic        MemEn, MemWr, Busy, Done, Error;

    ev_t sb[$];
    int passed = 0;
    int total = 0;

    word_store_sequencer #(.ADDR_WIDTH(16), .MAX_WAIT(15)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Data(Data), .Address(Address),
        .ByteOnly(ByteOnly), .BigEndian(BigEndian), .MemReady(MemReady),
        .MemAddr(MemAddr), .MemData(MemData), .MemEn(MemEn), .MemWr(MemWr),
        .Busy(Busy), .Done(Done), .Error(Error)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // kind 0 = accepted byte write, 1 = Done pulse, 2 = Error pulse
    task automatic expect_ev(input int kind, input logic [15:0] a, input logic [7:0] d);
        ev_t e;
        if (sb.size() == 0) begin
            check("sb_unexpected_event", kind, 32'hFFFF);
        end else begin
            e = sb.pop_front();
            check("sb_kind", kind, e.kind);
            if (kind == 0 && e.kind == 0) begin
                check("sb_addr", a, e.addr);
                check("sb_data", d, e.data);
            end
        end
    endtask

    // monitor: every accepted write and every Done/Error pulse must match the next expected event
    always @(negedge Clock) begin
        if (Reset) begin
            if (MemEn && MemWr && MemReady) expect_ev(0, MemAddr, MemData);
            if (Done) expect_ev(1, 16'h0, 8'h0);
            if (Error) expect_ev(2, 16'h0, 8'h0);
        end
    end

    task automatic store(input logic [15:0] d, input logic [15:0] a, input logic bo, input logic be,
                         input int lows, input logic [15:0] a0, input logic [7:0] d0,
                         input logic [15:0] a1, input logic [7:0] d1,
                         input int exp_end, input logic exp_err, input logic mid);
        int cyc, busy_n, lowc;
        if (exp_err) begin
            sb.push_back('{2, 16'h0, 8'h0});
        end else begin
            sb.push_back('{0, a0, d0});
            if (!bo) sb.push_back('{0, a1, d1});
            sb.push_back('{1, 16'h0, 8'h0});
        end
        Data = d; Address = a; ByteOnly = bo; BigEndian = be; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0; Data = ~d; Address = ~a; ByteOnly = ~bo; BigEndian = ~be;
        cyc = 1; busy_n = 0; lowc = 0;
        while (!(Done || Error) && cyc < 40) begin
            if (Busy) busy_n++;
            if (MemEn && lowc < lows) begin
                MemReady = 1'b0;
                lowc++;
            end else begin
                MemReady = MemEn;
                lowc = 0;
            end
            Start = mid && cyc == 5;
            if (Start) begin Data = 16'hDEAD; Address = 16'h4444; end
            @(posedge Clock); #1;
            cyc++;
        end
        MemReady = 1'b0;
        check("end_cycle", cyc, exp_end);
        check("busy_cycles", busy_n, exp_end - 1);
        check("error_flag", Error, exp_err);
        Start = mid;
        @(posedge Clock); #1;
        Start = 1'b0;
        check("idle_after", {Busy, MemEn, MemWr, Done, Error}, 5'b0);
    endtask

    initial begin
        logic seen;
        repeat (2) @(posedge Clock);
        #1;
        check("reset_ctrl", {Busy, MemEn, MemWr, Done, Error}, 5'b0);
        check("reset_addr_data", {MemAddr, MemData}, 24'h0);
        Reset = 1'b1;
        @(posedge Clock); #1;
        store(16'hA55A, 16'h0010, 1'b0, 1'b0, 0, 16'h0010, 8'h5A, 16'h0011, 8'hA5, 3, 1'b0, 1'b0);
        store(16'h1234, 16'h0020, 1'b0, 1'b1, 0, 16'h0020, 8'h12, 16'h0021, 8'h34, 3, 1'b0, 1'b0);
        store(16'hBEEF, 16'h0100, 1'b1, 1'b0, 0, 16'h0100, 8'hEF, 16'h0000, 8'h00, 2, 1'b0, 1'b0);
        store(16'hBEEF, 16'h0200, 1'b1, 1'b1, 0, 16'h0200, 8'hEF, 16'h0000, 8'h00, 2, 1'b0, 1'b0);
        store(16'h7E81, 16'hFFFF, 1'b0, 1'b0, 3, 16'hFFFF, 8'h81, 16'h0000, 8'h7E, 9, 1'b0, 1'b1);
        store(16'h1111, 16'h0030, 1'b0, 1'b0, 99, 16'h0, 8'h0, 16'h0, 8'h0, 16, 1'b1, 1'b0);
        store(16'h0F0E, 16'h0040, 1'b0, 1'b1, 0, 16'h0040, 8'h0F, 16'h0041, 8'h0E, 3, 1'b0, 1'b0);
        // reset while the second byte is waiting
        sb.push_back('{0, 16'h0050, 8'h99});
        Data = 16'h6699; Address = 16'h0050; ByteOnly = 1'b0; BigEndian = 1'b0; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0; MemReady = 1'b1;
        @(posedge Clock); #1;
        check("rst_mid_busy", {Busy, MemAddr}, {1'b1, 16'h0051});
        MemReady = 1'b0; Reset = 1'b0;
        @(posedge Clock); #1;
        check("rst_mid_ctrl", {Busy, MemEn, MemWr, Done, Error}, 5'b0);
        check("rst_mid_addr_data", {MemAddr, MemData}, 24'h0);
        Reset = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(posedge Clock); #1;
            seen = seen | Done | Error | Busy;
        end
        check("rst_no_pulse", seen, 1'b0);
        store(16'hC3D4, 16'h0060, 1'b0, 1'b0, 1, 16'h0060, 8'hD4, 16'h0061, 8'hC3, 5, 1'b0, 1'b0);
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
